// File: rtl/m_branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters. Lookups are answered one cycle later from registered outputs.
// Resolved conditional branches train the table. After reset a sweep
// invalidates every entry before the table starts answering.
module m_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              busy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Counter encodings: weakly taken is MSB set with all lower bits clear.
  localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX     = '1;
  localparam logic [IDX_W-1:0] PTR_LAST    = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               busy_q;
  logic               hit_q;
  logic               taken_q;
  logic [ADDR_W-1:0]  target_out_q;

  // Table storage; contents are only meaningful once the sweep has run.
  logic               valid_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Address split: the two byte-offset bits never take part.
  logic [IDX_W-1:0]   look_idx;
  logic [TAG_W-1:0]   look_tag;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               unused_offset_bits;

  assign look_idx = lookup_pc[IDX_W+1:2];
  assign look_tag = lookup_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx  = upd_pc[IDX_W+1:2];
  assign upd_tag  = upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_offset_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  logic              look_hit_d;
  logic              upd_hit;
  logic [CTR_W-1:0]  upd_ctr_cur;
  logic [CTR_W-1:0]  upd_ctr_d;

  // Lookup match against the pre-edge table; nothing answers during the sweep.
  always_comb begin
    look_hit_d = (state_q == S_READY) && valid_q[look_idx] &&
                 (tag_q[look_idx] == look_tag);
  end

  // Training decode: hit test and saturating counter step for the update slot.
  always_comb begin
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_cur = ctr_q[upd_idx];
    upd_ctr_d   = upd_ctr_cur;
    if (upd_taken) begin
      if (upd_ctr_cur != CTR_MAX) upd_ctr_d = upd_ctr_cur + CTR_W'(1);
    end else begin
      if (upd_ctr_cur != '0) upd_ctr_d = upd_ctr_cur - CTR_W'(1);
    end
  end

  // Sweep sequencer: reset restarts the sweep, READY is left only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else if (ce && (state_q == S_INIT)) begin
      ptr_q <= ptr_q + IDX_W'(1);
      if (ptr_q == PTR_LAST) begin
        state_q <= S_READY;
        busy_q  <= 1'b0;
      end
    end
  end

  // Table writes: sweep clearing in INIT, branch training in READY.
  always_ff @(posedge clk) begin
    if (!rst && ce) begin
      if (state_q == S_INIT) begin
        valid_q[ptr_q] <= 1'b0;
        ctr_q[ptr_q]   <= CTR_WEAK_NT;
      end else if (upd_valid) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= upd_ctr_d;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          ctr_q[upd_idx]    <= CTR_WEAK_T;
        end
      end
    end
  end

  // Registered prediction; the target is forced to zero on a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q        <= 1'b0;
      taken_q      <= 1'b0;
      target_out_q <= '0;
    end else if (ce) begin
      hit_q        <= look_hit_d;
      taken_q      <= look_hit_d && ctr_q[look_idx][CTR_W-1];
      target_out_q <= look_hit_d ? target_q[look_idx] : '0;
    end
  end

  assign pred_hit    = hit_q;
  assign pred_taken  = taken_q;
  assign pred_target = target_out_q;
  assign busy        = busy_q;

endmodule
